// File: rtl/ifetch_prefetch_queue.sv
// Purpose: sequential instruction fetch front end with a DEPTH-entry {pc, inst} prefetch FIFO and branch redirect flush.
// Latency: request accepted in cycle N with memory latency L is pushed at edge N+L and offered downstream from then on (no bypass).
// Backpressure: new requests only while outstanding+buffered < DEPTH; the FIFO can never overflow, so memory responses need no ready.
module ifetch_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    input  logic        if_ready
);

    localparam int          CW      = $clog2(DEPTH + 1);
    localparam int          AW      = $clog2(DEPTH);
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_rsp_pc;
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_drop_cnt;
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [31:0]   r_mem_pc   [DEPTH];
    logic [31:0]   r_mem_inst [DEPTH];

    logic [CW:0]   w_credit_used;
    logic [31:0]   w_redir_target;
    logic          w_req_fire;
    logic          w_rsp;
    logic          w_push;
    logic          w_drop;
    logic          w_pop;

    // Buffered entries plus requests still in flight form the credit pool;
    // count here is the pre-pop value so a pop never frees a slot early.
    assign w_credit_used  = {1'b0, r_outstanding} + {1'b0, r_count};
    assign w_redir_target = redirect_pc & 32'hFFFF_FFFC;

    assign imem_req_valid = reset_n & ~redirect_valid & (w_credit_used < DEPTH_W);
    assign imem_req_addr  = r_fetch_pc;
    assign w_req_fire     = imem_req_valid & imem_req_ready;

    // A response with nothing outstanding is ignored so the counter cannot underflow.
    assign w_rsp  = imem_rsp_valid & (r_outstanding != '0);
    assign w_push = w_rsp & ~redirect_valid & (r_drop_cnt == '0);
    assign w_drop = w_rsp & ~redirect_valid & (r_drop_cnt != '0);

    assign if_valid = (r_count != '0) & ~redirect_valid;
    assign if_pc    = r_mem_pc[r_rd_ptr];
    assign if_inst  = r_mem_inst[r_rd_ptr];
    assign w_pop    = if_valid & if_ready;

    // Fetch address: restart on redirect, advance one word per accepted request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fetch_pc <= RESET_PC;
        end else if (redirect_valid) begin
            r_fetch_pc <= w_redir_target;
        end else if (w_req_fire) begin
            r_fetch_pc <= r_fetch_pc + 32'd4;
        end
    end

    // PC tag for the next kept response; responses return in order so a counter suffices.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rsp_pc <= RESET_PC;
        end else if (redirect_valid) begin
            r_rsp_pc <= w_redir_target;
        end else if (w_push) begin
            r_rsp_pc <= r_rsp_pc + 32'd4;
        end
    end

    // In-flight tracking; on redirect everything still outstanding is wrong-path and marked for drop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
        end else if (redirect_valid) begin
            r_outstanding <= r_outstanding - CW'(w_rsp);
            r_drop_cnt    <= r_outstanding - CW'(w_rsp);
        end else begin
            r_outstanding <= r_outstanding + CW'(w_req_fire) - CW'(w_rsp);
            r_drop_cnt    <= r_drop_cnt - CW'(w_drop);
        end
    end

    // FIFO occupancy and pointers; redirect flushes, pointers wrap naturally (DEPTH is a power of 2).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (redirect_valid) begin
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // FIFO storage is cleared on reset so the head reads as zero until the first push.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_pc[i]   <= '0;
                r_mem_inst[i] <= '0;
            end
        end else if (w_push) begin
            r_mem_pc[r_wr_ptr]   <= r_rsp_pc;
            r_mem_inst[r_wr_ptr] <= imem_rsp_data;
        end
    end

    // The credit rule guarantees a kept response always finds a free slot.
    always_ff @(posedge clk) begin
        if (reset_n && w_push) begin
            assert (r_count != DEPTH_C);
        end
    end

endmodule

// File: tb/tb_ifetch_prefetch_queue.sv
module tb_ifetch_prefetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_ready;

    always #5 clk = ~clk;

    ifetch_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_inst        (if_inst),
        .if_ready       (if_ready)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Stimulus knobs applied by step()
    logic        tb_rst_n    = 1'b0;
    logic        tb_req_rdy  = 1'b1;
    logic        tb_if_rdy   = 1'b1;
    logic        tb_redir    = 1'b0;
    logic [31:0] tb_redir_pc = 32'h0;
    int          tb_lat      = 1;

    // Observed DUT outputs of the last step
    logic        o_req_vld, o_if_vld, o_req_fire, o_pop;
    logic [31:0] o_req_addr, o_if_pc, o_if_inst;

    // Memory environment: in-order queue of accepted addresses with ready times
    logic [31:0] mq_addr[$];
    int          mq_due[$];

    // Reference model: buffered entries, wrong-path flags of in-flight requests, next fetch address
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;
    ent_t        m_fifo[$];
    bit          m_wrong[$];
    logic [31:0] m_fetch_pc = RESET_PC;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h0100_0193) ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (cycle %0d): got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // One clock cycle: drive at negedge, compare against the model, then advance the model.
    task automatic step();
        logic        rsp, e_req_vld, e_if_vld;
        logic [31:0] ra;
        bit          w;
        @(negedge clk);
        reset_n        = tb_rst_n;
        imem_req_ready = tb_req_rdy;
        if_ready       = tb_if_rdy;
        redirect_valid = tb_redir;
        redirect_pc    = tb_redir_pc;
        rsp = tb_rst_n && (mq_addr.size() > 0) && (mq_due[0] <= cyc);
        ra  = rsp ? mq_addr[0] : 32'h0;
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? mem_word(ra) : $urandom;
        #1;
        o_req_vld  = imem_req_valid;
        o_req_addr = imem_req_addr;
        o_if_vld   = if_valid;
        o_if_pc    = if_pc;
        o_if_inst  = if_inst;
        if (!tb_rst_n) begin
            chk("rst_req_valid", o_req_vld, 0);
            chk("rst_if_valid", o_if_vld, 0);
            chk("rst_if_pc", o_if_pc, 0);
            chk("rst_if_inst", o_if_inst, 0);
            m_fifo.delete();
            m_wrong.delete();
            mq_addr.delete();
            mq_due.delete();
            m_fetch_pc = RESET_PC;
            o_req_fire = 1'b0;
            o_pop      = 1'b0;
        end else begin
            e_req_vld = !tb_redir && ((m_wrong.size() + m_fifo.size()) < DEPTH);
            e_if_vld  = !tb_redir && (m_fifo.size() != 0);
            chk("req_valid", o_req_vld, e_req_vld);
            chk("req_addr", o_req_addr, m_fetch_pc);
            chk("if_valid", o_if_vld, e_if_vld);
            if (e_if_vld) begin
                chk("if_pc", o_if_pc, m_fifo[0].pc);
                chk("if_inst", o_if_inst, m_fifo[0].inst);
            end
            o_req_fire = e_req_vld && tb_req_rdy;
            o_pop      = e_if_vld && tb_if_rdy;
            if (rsp) begin
                void'(mq_addr.pop_front());
                void'(mq_due.pop_front());
            end
            if (tb_redir) begin
                if (rsp) void'(m_wrong.pop_front());
                foreach (m_wrong[i]) m_wrong[i] = 1'b1;
                m_fifo.delete();
                m_fetch_pc = {tb_redir_pc[31:2], 2'b00};
            end else begin
                if (o_pop) void'(m_fifo.pop_front());
                if (rsp) begin
                    w = m_wrong.pop_front();
                    if (!w) m_fifo.push_back('{pc: ra, inst: mem_word(ra)});
                end
                if (o_req_fire) begin
                    mq_addr.push_back(m_fetch_pc);
                    mq_due.push_back(cyc + tb_lat);
                    m_wrong.push_back(1'b0);
                    m_fetch_pc = m_fetch_pc + 32'd4;
                end
            end
        end
        cyc++;
    endtask

    task automatic do_reset();
        tb_rst_n = 1'b0;
        tb_redir = 1'b0;
        step();
        step();
        tb_rst_n = 1'b1;
    endtask

    initial begin
        int fires;
        int n_pc8;
        int prob;
        bit found;
        reset_n        = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        if_ready       = 1'b0;

        // 1: streaming, L=1, first if_valid two cycles after release
        do_reset();
        tb_lat = 1; tb_req_rdy = 1'b1; tb_if_rdy = 1'b1;
        step(); chk("t1_c0_req_addr", o_req_addr, 32'h0); chk("t1_c0_if_valid", o_if_vld, 0);
        step(); chk("t1_c1_if_valid", o_if_vld, 0);
        step(); chk("t1_c2_if_valid", o_if_vld, 1); chk("t1_c2_if_pc", o_if_pc, 32'h0);
        step(); chk("t1_c3_if_pc", o_if_pc, 32'h4);
        step(); chk("t1_c4_if_pc", o_if_pc, 32'h8);
        step(); chk("t1_c5_if_pc", o_if_pc, 32'hC); chk("t1_c5_if_inst", o_if_inst, mem_word(32'hC));

        // 2: downstream stalled, exactly DEPTH requests then drain in order
        do_reset();
        tb_if_rdy = 1'b0;
        fires = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (o_req_vld && tb_req_rdy) fires++;
        end
        chk("t2_req_count", fires, 4);
        chk("t2_req_valid_off", o_req_vld, 0);
        chk("t2_held_addr", o_req_addr, 32'h10);
        tb_if_rdy = 1'b1;
        step(); chk("t2_pop0_pc", o_if_pc, 32'h0); chk("t2_pop0_req_valid", o_req_vld, 0);
        step(); chk("t2_pop1_pc", o_if_pc, 32'h4); chk("t2_pop1_req_valid", o_req_vld, 1);
        chk("t2_pop1_req_addr", o_req_addr, 32'h10);
        step(); chk("t2_pop2_pc", o_if_pc, 32'h8);
        step(); chk("t2_pop3_pc", o_if_pc, 32'hC);

        // 3: L=3, two requests in flight, redirect to 0x100 drops both
        do_reset();
        tb_lat = 3; tb_if_rdy = 1'b1;
        step(); step();
        tb_redir = 1'b1; tb_redir_pc = 32'h100;
        step(); chk("t3_redir_req_valid", o_req_vld, 0);
        tb_redir = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (o_if_vld) found = 1'b1;
        end
        chk("t3_found", found, 1);
        chk("t3_if_pc", o_if_pc, 32'h100);
        chk("t3_if_inst", o_if_inst, mem_word(32'h100));

        // 4: redirect coincident with response and if_ready while count=2
        do_reset();
        tb_lat = 1; tb_if_rdy = 1'b0;
        step(); step(); step();
        tb_redir = 1'b1; tb_redir_pc = 32'h203; tb_if_rdy = 1'b1;
        step();
        chk("t4_rsp_in_redir", imem_rsp_valid, 1);
        chk("t4_if_valid", o_if_vld, 0);
        tb_redir = 1'b0; tb_if_rdy = 1'b0;
        step();
        chk("t4_flushed", o_if_vld, 0);
        chk("t4_target", o_req_addr, 32'h200);

        // 5: memory stalls at fetch_pc=0x8 for 5 cycles
        do_reset();
        tb_if_rdy = 1'b1; tb_req_rdy = 1'b1;
        step(); step();
        tb_req_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t5_hold_addr", o_req_addr, 32'h8);
            chk("t5_hold_valid", o_req_vld, 1);
        end
        tb_req_rdy = 1'b1;
        n_pc8 = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (o_pop && o_if_pc == 32'h8) n_pc8++;
        end
        chk("t5_pc8_delivered", n_pc8, 1);

        // 6: reset mid-stream with count=3
        do_reset();
        tb_if_rdy = 1'b0;
        step(); step(); step(); step();
        chk("t6_pre_if_valid", o_if_vld, 1);
        tb_rst_n = 1'b0;
        step();
        chk("t6_if_valid_drop", o_if_vld, 0);
        chk("t6_req_valid_drop", o_req_vld, 0);
        tb_rst_n = 1'b1; tb_if_rdy = 1'b1;
        step();
        chk("t6_restart_addr", o_req_addr, RESET_PC);
        chk("t6_restart_valid", o_req_vld, 1);

        // Randomized traffic checked every cycle against the model
        prob = 6;
        for (int i = 0; i < 4000; i++) begin
            if (i % 200 == 0) prob = $urandom_range(1, 10);
            tb_req_rdy  = ($urandom_range(0, 9) < 7);
            tb_if_rdy   = ($urandom_range(0, 9) < prob);
            tb_redir    = ($urandom_range(0, 99) < 4);
            tb_redir_pc = $urandom;
            tb_lat      = $urandom_range(1, 4);
            tb_rst_n    = ($urandom_range(0, 499) != 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
